// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB receive byte-assembly path.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    RECV,
    ERROR
  } rx_state_t;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'h80;
  localparam int unsigned STUFF_LEN_DEF = 6;
  localparam int unsigned MAX_BYTES_DEF = 64;

endpackage

// File: rtl/rx_bit_unstuffer.sv
// Tracks consecutive 1s on accepted bits and classifies the bit after a run
// of STUFF_LEN ones as a droppable stuff bit or a stuffing violation.
module rx_bit_unstuffer
  import usb_rx_pkg::*;
#(
  parameter int unsigned STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic bit_strobe,
  input  logic d,
  output logic bit_valid_c,
  output logic stuff_err_c
);

  localparam int unsigned OW = $clog2(STUFF_LEN + 1);

  logic [OW-1:0] ones_cnt;
  logic          stuff_slot_c;

  assign stuff_slot_c = (ones_cnt == OW'(STUFF_LEN));
  assign bit_valid_c  = bit_strobe & ~stuff_slot_c;
  assign stuff_err_c  = bit_strobe & stuff_slot_c & d;

  // A stuff-slot bit always restarts the run: a 0 is dropped, a 1 aborts the packet.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones_cnt <= '0;
    end else if (clear) begin
      ones_cnt <= '0;
    end else if (bit_strobe) begin
      if (stuff_slot_c || !d) ones_cnt <= '0;
      else                    ones_cnt <= ones_cnt + OW'(1);
    end
  end

endmodule

// File: rtl/rx_byte_assembler.sv
// Receive-side byte assembler: checks SYNC, unstuffs, packs bytes LSB-first
// and writes completed payload bytes to rx_fifo.
module rx_byte_assembler
  import usb_rx_pkg::*;
#(
  parameter int unsigned MAX_BYTES = MAX_BYTES_DEF,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           d_orig,
  input  logic                           shift_enable,
  input  logic                           eop,
  input  logic                           full,
  output logic                           w_enable,
  output logic [7:0]                     w_data,
  output logic                           rcving,
  output logic                           r_error,
  output logic [$clog2(MAX_BYTES+1)-1:0] byte_count
);

  localparam int unsigned BCW = $clog2(MAX_BYTES + 1);

  rx_state_t       state, state_d;
  logic [7:0]      shift_reg, shift_d;
  logic [2:0]      bit_cnt, bit_cnt_d;
  logic            w_enable_d, rcving_d, r_error_d;
  logic [7:0]      w_data_d;
  logic [BCW-1:0]  byte_count_d;

  logic            in_pkt_c, bit_strobe_c, unstuff_clear_c;
  logic            bit_valid_c, stuff_err_c;
  logic [7:0]      shifted_c;
  logic            byte_done_c;

  assign in_pkt_c        = (state == SYNC) || (state == RECV);
  assign bit_strobe_c    = shift_enable & ~eop & in_pkt_c;
  assign unstuff_clear_c = ~in_pkt_c | eop;
  assign shifted_c       = {d_orig, shift_reg[7:1]};
  assign byte_done_c     = (bit_cnt == 3'd7);

  rx_bit_unstuffer #(
    .STUFF_LEN (STUFF_LEN)
  ) u_unstuffer (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (unstuff_clear_c),
    .bit_strobe  (bit_strobe_c),
    .d           (d_orig),
    .bit_valid_c (bit_valid_c),
    .stuff_err_c (stuff_err_c)
  );

  // Next-state and next-output logic; eop takes priority over a same-cycle bit.
  always_comb begin
    state_d      = state;
    shift_d      = shift_reg;
    bit_cnt_d    = bit_cnt;
    w_enable_d   = 1'b0;
    w_data_d     = w_data;
    rcving_d     = rcving;
    r_error_d    = r_error;
    byte_count_d = byte_count;

    case (state)
      IDLE: begin
        if (shift_enable && !d_orig && !eop) begin
          state_d      = SYNC;
          shift_d      = shifted_c;
          bit_cnt_d    = 3'd1;
          rcving_d     = 1'b1;
          r_error_d    = 1'b0;
          byte_count_d = '0;
        end
      end

      SYNC: begin
        if (eop) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          rcving_d  = 1'b0;
          r_error_d = 1'b1;
        end else if (stuff_err_c) begin
          state_d   = ERROR;
          r_error_d = 1'b1;
        end else if (bit_valid_c) begin
          shift_d   = shifted_c;
          bit_cnt_d = bit_cnt + 3'd1;
          if (byte_done_c) begin
            if (shifted_c == SYNC_BYTE) begin
              state_d = RECV;
            end else begin
              state_d   = ERROR;
              r_error_d = 1'b1;
            end
          end
        end
      end

      RECV: begin
        if (eop) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          rcving_d  = 1'b0;
          if (bit_cnt != 3'd0) r_error_d = 1'b1;
        end else if (stuff_err_c) begin
          state_d   = ERROR;
          r_error_d = 1'b1;
        end else if (bit_valid_c) begin
          shift_d   = shifted_c;
          bit_cnt_d = bit_cnt + 3'd1;
          if (byte_done_c) begin
            if (full || (byte_count >= BCW'(MAX_BYTES))) begin
              state_d   = ERROR;
              r_error_d = 1'b1;
            end else begin
              w_enable_d   = 1'b1;
              w_data_d     = shifted_c;
              byte_count_d = byte_count + BCW'(1);
            end
          end
        end
      end

      ERROR: begin
        r_error_d = 1'b1;
        if (eop) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          rcving_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      w_enable   <= 1'b0;
      w_data     <= '0;
      rcving     <= 1'b0;
      r_error    <= 1'b0;
      byte_count <= '0;
    end else begin
      state      <= state_d;
      shift_reg  <= shift_d;
      bit_cnt    <= bit_cnt_d;
      w_enable   <= w_enable_d;
      w_data     <= w_data_d;
      rcving     <= rcving_d;
      r_error    <= r_error_d;
      byte_count <= byte_count_d;
    end
  end

endmodule

// File: tb/tb_rx_byte_assembler.sv
// Scoreboard bench for rx_byte_assembler: expected FIFO writes are queued by
// the stimulus and popped by an independent write monitor.
module tb_rx_byte_assembler;

  localparam int unsigned MAXB = 64;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_orig;
  logic       shift_enable;
  logic       eop;
  logic       full;
  logic       w_enable;
  logic [7:0] w_data;
  logic       rcving;
  logic       r_error;
  logic [6:0] byte_count;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   tb_ones     = 0;

  rx_byte_assembler #(
    .MAX_BYTES (MAXB),
    .SYNC_BYTE (8'h80),
    .STUFF_LEN (6)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_orig       (d_orig),
    .shift_enable (shift_enable),
    .eop          (eop),
    .full         (full),
    .w_enable     (w_enable),
    .w_data       (w_data),
    .rcving       (rcving),
    .r_error      (r_error),
    .byte_count   (byte_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write monitor: every w_enable pulse must match the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (w_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got w_data %0h, expected no write (cycle %0d)", w_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("w_data", 32'(w_data), 32'(mon_e.data));
        check("w_latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete, expected finish");
    $fatal(1, "timeout");
  end

  // One raw bit strobe followed by one idle cycle; starts and ends on a negedge.
  task automatic send_bit(input logic b);
    shift_enable = 1'b1;
    d_orig       = b;
    @(negedge clk);
    shift_enable = 1'b0;
    d_orig       = 1'b0;
    @(negedge clk);
  endtask

  // Data bit with transmitter-side stuffing inserted when six 1s have gone by.
  task automatic send_data_bit(input logic b);
    if (tb_ones == 6) begin
      send_bit(1'b0);
      tb_ones = 0;
    end
    send_bit(b);
    tb_ones = b ? tb_ones + 1 : 0;
  endtask

  task automatic send_byte(input logic [7:0] data, input bit expect_wr);
    for (int i = 0; i < 8; i++) begin
      if (tb_ones == 6) begin
        send_bit(1'b0);
        tb_ones = 0;
      end
      if (i == 7 && expect_wr) exp_q.push_back('{data: data, cyc: cyc + 1});
      send_bit(data[i]);
      tb_ones = data[i] ? tb_ones + 1 : 0;
    end
  endtask

  task automatic send_sync();
    tb_ones = 0;
    for (int i = 0; i < 7; i++) send_data_bit(1'b0);
    send_data_bit(1'b1);
  endtask

  task automatic send_eop();
    eop = 1'b1;
    @(negedge clk);
    eop = 1'b0;
    @(negedge clk);
    tb_ones = 0;
  endtask

  task automatic drain_check();
    repeat (3) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    n_rst        = 1'b0;
    d_orig       = 1'b0;
    shift_enable = 1'b0;
    eop          = 1'b0;
    full         = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_w_enable", 32'(w_enable), 32'd0);
    check("reset_w_data", 32'(w_data), 32'd0);
    check("reset_rcving", 32'(rcving), 32'd0);
    check("reset_r_error", 32'(r_error), 32'd0);
    check("reset_byte_count", 32'(byte_count), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // Good packet: two bytes, eop on a byte boundary.
    send_sync();
    check("t2_rcving_after_sync", 32'(rcving), 32'd1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    check("t2_byte_count", 32'(byte_count), 32'd2);
    send_eop();
    check("t2_rcving_end", 32'(rcving), 32'd0);
    check("t2_r_error", 32'(r_error), 32'd0);
    check("t2_byte_count_end", 32'(byte_count), 32'd2);
    drain_check();

    // Stuffed 0xFF bytes: stuff bits are dropped and never counted.
    send_sync();
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_eop();
    check("t3_byte_count", 32'(byte_count), 32'd2);
    check("t3_r_error", 32'(r_error), 32'd0);
    check("t3_rcving", 32'(rcving), 32'd0);
    drain_check();

    // Asynchronous reset in the middle of SYNC.
    for (int i = 0; i < 3; i++) send_data_bit(1'b0);
    check("t1_rcving_before", 32'(rcving), 32'd1);
    n_rst = 1'b0;
    #1;
    check("t1_w_enable", 32'(w_enable), 32'd0);
    check("t1_w_data", 32'(w_data), 32'd0);
    check("t1_rcving", 32'(rcving), 32'd0);
    check("t1_r_error", 32'(r_error), 32'd0);
    check("t1_byte_count", 32'(byte_count), 32'd0);
    @(negedge clk);
    n_rst   = 1'b1;
    tb_ones = 0;
    repeat (4) @(negedge clk);
    check("t1_rcving_after", 32'(rcving), 32'd0);
    drain_check();

    // Seven 1s in RECV: stuffing violation, then sticky error until next start.
    send_sync();
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    check("t4_r_error", 32'(r_error), 32'd1);
    send_byte(8'h12, 1'b0);
    check("t4_rcving_in_error", 32'(rcving), 32'd1);
    send_eop();
    check("t4_rcving_end", 32'(rcving), 32'd0);
    repeat (4) @(negedge clk);
    check("t4_r_error_sticky", 32'(r_error), 32'd1);
    send_bit(1'b0);
    check("t4_r_error_cleared", 32'(r_error), 32'd0);
    check("t4_rcving_restart", 32'(rcving), 32'd1);
    send_eop();
    drain_check();

    // Bad SYNC pattern 0000_0011.
    tb_ones = 0;
    for (int i = 0; i < 6; i++) send_data_bit(1'b0);
    send_data_bit(1'b1);
    send_data_bit(1'b1);
    check("t5_r_error_bad_sync", 32'(r_error), 32'd1);
    send_byte(8'h44, 1'b0);
    send_eop();
    check("t5_rcving", 32'(rcving), 32'd0);
    check("t5_byte_count", 32'(byte_count), 32'd0);
    drain_check();

    // FIFO full when the third byte completes.
    send_sync();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    full = 1'b1;
    send_byte(8'h33, 1'b0);
    full = 1'b0;
    check("t5_full_r_error", 32'(r_error), 32'd1);
    check("t5_full_byte_count", 32'(byte_count), 32'd2);
    send_eop();
    drain_check();

    // eop after four bits of a byte.
    send_sync();
    send_byte(8'h5A, 1'b1);
    send_data_bit(1'b0);
    send_data_bit(1'b1);
    send_data_bit(1'b0);
    send_data_bit(1'b1);
    send_eop();
    check("t6_partial_r_error", 32'(r_error), 32'd1);
    check("t6_partial_rcving", 32'(rcving), 32'd0);
    check("t6_partial_byte_count", 32'(byte_count), 32'd1);
    drain_check();

    // eop coincident with the 8th bit: that bit is discarded.
    send_sync();
    for (int i = 0; i < 7; i++) send_data_bit(i inside {0, 1, 6});
    shift_enable = 1'b1;
    d_orig       = 1'b1;
    eop          = 1'b1;
    @(negedge clk);
    shift_enable = 1'b0;
    d_orig       = 1'b0;
    eop          = 1'b0;
    @(negedge clk);
    tb_ones = 0;
    check("t6_coinc_r_error", 32'(r_error), 32'd1);
    check("t6_coinc_rcving", 32'(rcving), 32'd0);
    check("t6_coinc_byte_count", 32'(byte_count), 32'd0);
    drain_check();

    // MAX_BYTES payload accepted; one more byte overflows.
    send_sync();
    for (int i = 0; i < MAXB; i++) send_byte(8'(i * 5 + 1), 1'b1);
    check("t7_byte_count_max", 32'(byte_count), 32'(MAXB));
    check("t7_r_error_at_max", 32'(r_error), 32'd0);
    send_byte(8'hEE, 1'b0);
    check("t7_overflow_r_error", 32'(r_error), 32'd1);
    check("t7_byte_count_sat", 32'(byte_count), 32'(MAXB));
    send_eop();
    check("t7_rcving_end", 32'(rcving), 32'd0);
    drain_check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
